// File: rtl/mem_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_pkg
//   Shared definitions for the memory-stage access controller: FSM state
//   encodings (2-bit), the default ack timeout, m_wr direction encodings,
//   the timeout counter width and the illegal-access predicate.
// ---------------------------------------------------------------------------
package mem_access_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Default number of WAIT cycles allowed before an access is aborted.
  // Legal range is 2..255 so that TIMEOUT-1 fits the 8-bit counter.
  localparam int unsigned DEF_TIMEOUT = 64;

  localparam int unsigned CNT_W = 8;

  localparam logic MWR_READ  = 1'b0;
  localparam logic MWR_WRITE = 1'b1;

  // An access is illegal when the byte address is odd (all words are
  // 16-bit aligned) or when load and store are requested together.
  function automatic logic is_illegal(input logic addr_lsb,
                                      input logic rd,
                                      input logic wr);
    return addr_lsb | (rd & wr);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// ---------------------------------------------------------------------------
// mem_timeout_cnt
//   8-bit WAIT-cycle counter used to abort accesses whose ack never arrives.
//   Ports:
//     clk  in  clock
//     rst  in  synchronous active-low reset (counter -> 0)
//     clr  in  clear counter (has priority over en)
//     en   in  increment counter
//     hit  out counter equals TIMEOUT-1
// ---------------------------------------------------------------------------
module mem_timeout_cnt
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//   Memory-stage front end. Takes the execute-stage address/store data and
//   MemRead/MemWrite, issues one word access at a time to a variable-latency
//   memory over req/busy/ack, stalls the pipeline while the access is in
//   flight and returns load data to writeback. Odd addresses, read+write
//   together and ack timeouts are reported with a one-cycle err pulse.
//   Ports:
//     clk, rst            clock, synchronous active-low reset
//     ex_valid            execute-stage result valid
//     mem_read, mem_write load / store request
//     addr, wr_data       byte address, store data
//     stall               freeze upstream stages (combinational)
//     rd_data, rd_valid   load data, one-cycle completion pulse
//     err                 one-cycle abort pulse
//     m_req, m_wr         memory request, direction (1 = write)
//     m_addr, m_wdata     registered address / store data
//     m_busy, m_ack       memory back-pressure, completion
//     m_rdata             memory read data (valid with m_ack)
// ---------------------------------------------------------------------------
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              stall,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              err,
  output logic              m_req,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_busy,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
);

  state_t            state_q,    state_d;
  logic [ADDR_W-1:0] m_addr_q,   m_addr_d;
  logic [DATA_W-1:0] m_wdata_q,  m_wdata_d;
  logic              m_wr_q,     m_wr_d;
  logic              m_req_q,    m_req_d;
  logic [DATA_W-1:0] rd_data_q,  rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q,      err_d;

  logic request;
  logic illegal;
  logic cnt_clr;
  logic cnt_en;
  logic cnt_hit;

  assign request = ex_valid & (mem_read | mem_write);
  assign illegal = is_illegal(addr[0], mem_read, mem_write);

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .hit (cnt_hit)
  );

  // Next-state, datapath and output decode. rd_valid/err/m_req are
  // registered so they appear in the cycle after the deciding event.
  always_comb begin
    state_d    = state_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_wr_d     = m_wr_q;
    m_req_d    = 1'b0;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    stall      = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // m_ack is deliberately ignored here so a late ack after reset or
        // timeout cannot produce a spurious completion.
        if (request) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            stall     = 1'b1;
            m_addr_d  = addr;
            m_wdata_d = wr_data;
            m_wr_d    = mem_write ? MWR_WRITE : MWR_READ;
            m_req_d   = 1'b1;
            state_d   = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        stall   = 1'b1;
        cnt_clr = 1'b1;
        if (m_busy) begin
          m_req_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        stall  = 1'b1;
        cnt_en = 1'b1;
        // Ack is checked first so it wins over a timeout in the same cycle.
        if (m_ack) begin
          if (m_wr_q == MWR_READ) begin
            rd_data_d = m_rdata;
          end
          rd_valid_d = 1'b1;
          state_d    = ST_DONE;
        end else if (cnt_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_wr_q     <= 1'b0;
      m_req_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_wr_q     <= m_wr_d;
      m_req_q    <= m_req_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_wr     = m_wr_q;
  assign m_req    = m_req_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Directed and randomized bench for mem_access_ctrl. The bench plays the
//   memory (word store keyed by address) and predicts every output cycle by
//   cycle from the access timeline: accept, (busy+1) request cycles, WAIT
//   cycles until ack or timeout, then a completion or error cycle.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, mem_read, mem_write;
  logic [15:0] addr, wr_data;
  logic        stall;
  logic [15:0] rd_data;
  logic        rd_valid, err;
  logic        m_req, m_wr;
  logic [15:0] m_addr, m_wdata;
  logic        m_busy, m_ack;
  logic [15:0] m_rdata;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_rd;
  logic [15:0] mem_model [logic [15:0]];

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .DATA_W  (16),
    .ADDR_W  (16),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wr_data   (wr_data),
    .stall     (stall),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .err       (err),
    .m_req     (m_req),
    .m_wr      (m_wr),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_busy    (m_busy),
    .m_ack     (m_ack),
    .m_rdata   (m_rdata)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_read_word(input logic [15:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 16'hA5A5;
  endfunction

  task automatic idle_inputs();
    ex_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    m_busy    = 1'b0;
    m_ack     = 1'b0;
    m_rdata   = 16'($urandom);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_stall"},    stall,    1'b0);
    chk({tag, "_m_req"},    m_req,    1'b0);
    chk({tag, "_rd_valid"}, rd_valid, 1'b0);
    chk({tag, "_err"},      err,      1'b0);
    chk({tag, "_rd_data"},  rd_data,  exp_rd);
  endtask

  // One complete access. busy_n = cycles m_busy is held while requesting;
  // ack_w = WAIT cycle (1-based) carrying m_ack, > TO means never.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [15:0] a, input logic [15:0] d,
                            input int busy_n, input int ack_w);
    logic        bad;
    logic        done;
    logic [15:0] rv;
    bad  = a[0] | (rd & wr);
    done = 1'b0;

    // accept (or reject) cycle
    @(negedge clk);
    idle_inputs();
    ex_valid = 1'b1; mem_read = rd; mem_write = wr; addr = a; wr_data = d;
    #1;
    chk({tag, "_acc_stall"}, stall, !bad);
    chk({tag, "_acc_m_req"}, m_req, 1'b0);

    if (bad) begin
      @(negedge clk);
      idle_inputs();
      #1;
      chk({tag, "_err"},      err,      1'b1);
      chk({tag, "_m_req"},    m_req,    1'b0);
      chk({tag, "_stall"},    stall,    1'b0);
      chk({tag, "_rd_valid"}, rd_valid, 1'b0);
      @(negedge clk);
      #1;
      chk_quiet({tag, "_after_err"});
      return;
    end

    // request cycles
    for (int i = 0; i <= busy_n; i++) begin
      @(negedge clk);
      idle_inputs();
      m_busy = (i < busy_n);
      #1;
      chk({tag, "_req"},      m_req,   1'b1);
      chk({tag, "_m_wr"},     m_wr,    wr);
      chk({tag, "_m_addr"},   m_addr,  a);
      chk({tag, "_m_wdata"},  m_wdata, d);
      chk({tag, "_req_stall"}, stall,  1'b1);
    end

    // WAIT cycles
    for (int j = 1; j <= TO; j++) begin
      @(negedge clk);
      idle_inputs();
      if (j == ack_w) begin
        m_ack = 1'b1;
        rv    = mem_read_word(a);
        if (rd) m_rdata = rv;
      end
      #1;
      chk({tag, "_wait_m_req"}, m_req,    1'b0);
      chk({tag, "_wait_stall"}, stall,    1'b1);
      chk({tag, "_wait_rdv"},   rd_valid, 1'b0);
      if (j == ack_w) begin
        if (rd) exp_rd = rv;
        else    mem_model[a] = d;
        done = 1'b1;
        break;
      end
    end

    // completion or abort cycle
    @(negedge clk);
    idle_inputs();
    #1;
    chk({tag, "_rd_valid"}, rd_valid, done);
    chk({tag, "_err_end"},  err,      !done);
    chk({tag, "_rd_data"},  rd_data,  exp_rd);
    chk({tag, "_end_stall"}, stall,   1'b0);
    chk({tag, "_end_m_req"}, m_req,   1'b0);
  endtask

  initial begin
    logic [15:0] ra;
    int          kind;
    int          aw;

    // reset state
    rst = 1'b0;
    idle_inputs();
    addr = '0; wr_data = '0;
    exp_rd = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_quiet("reset");
    chk("reset_m_addr",  m_addr,  16'h0);
    chk("reset_m_wdata", m_wdata, 16'h0);
    chk("reset_m_wr",    m_wr,    1'b0);

    // ack in IDLE is ignored
    @(negedge clk);
    rst = 1'b1;
    m_ack = 1'b1; m_rdata = 16'hDEAD;
    @(negedge clk);
    idle_inputs();
    #1;
    chk_quiet("idle_ack");

    // 1: load with ack in first WAIT cycle
    mem_model[16'h0010] = 16'hBEEF;
    run_access("load1", 1'b1, 1'b0, 16'h0010, 16'h0, 0, 1);
    chk("load1_val", rd_data, 16'hBEEF);

    // 2: store with 3 busy cycles
    run_access("store2", 1'b0, 1'b1, 16'h0020, 16'h1234, 3, 1);
    chk("store2_rd_keep", rd_data, 16'hBEEF);

    // 3, 4: illegal accesses
    run_access("odd3",  1'b1, 1'b0, 16'h0011, 16'h0, 0, 1);
    run_access("both4", 1'b1, 1'b1, 16'h0030, 16'h5555, 0, 1);

    // 5: timeout, then a normal load; ack exactly at last WAIT cycle wins
    run_access("tmo5",   1'b1, 1'b0, 16'h0040, 16'h0, 1, TO + 10);
    run_access("after5", 1'b1, 1'b0, 16'h0020, 16'h0, 0, 2);
    chk("after5_val", rd_data, 16'h1234);
    run_access("ackwin", 1'b1, 1'b0, 16'h0010, 16'h0, 0, TO);

    // 6: reset in WAIT, late ack after release
    @(negedge clk);
    idle_inputs();
    ex_valid = 1'b1; mem_read = 1'b1; addr = 16'h0050;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    m_ack = 1'b1; m_rdata = 16'hCAFE;
    exp_rd = '0;
    #1;
    chk_quiet("rst6");
    chk("rst6_m_addr",  m_addr,  16'h0);
    chk("rst6_m_wdata", m_wdata, 16'h0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk_quiet("rst6_late_ack");

    // back-to-back loads
    run_access("b2b_a", 1'b1, 1'b0, 16'h0010, 16'h0, 0, 1);
    run_access("b2b_b", 1'b1, 1'b0, 16'h0020, 16'h0, 1, 3);
    chk("b2b_val", rd_data, 16'h1234);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 19);
      ra   = 16'h0100 + 16'(2 * $urandom_range(0, 7));
      aw   = (kind == 19) ? TO + 1 : $urandom_range(1, 6);
      if (kind == 0)
        run_access("rnd_odd", 1'b0, 1'b1, ra | 16'h1, 16'($urandom), 0, 1);
      else if (kind == 1)
        run_access("rnd_both", 1'b1, 1'b1, ra, 16'($urandom), 0, 1);
      else if (kind < 10 || kind == 19)
        run_access("rnd_ld", 1'b1, 1'b0, ra, 16'($urandom), $urandom_range(0, 3), aw);
      else
        run_access("rnd_st", 1'b0, 1'b1, ra, 16'($urandom), $urandom_range(0, 3), aw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
